// File: rtl/count_monitor_if.sv
// rtl/count_monitor_if.sv - count bus and monitor status/display signals
interface count_monitor_if #(
   parameter int N = 8
);
   logic [N-1:0] count;
   logic [N-1:0] count_q;
   logic         zero;
   logic         done;
   logic         wrap;
   logic [3:0]   wrap_cnt;
   logic [6:0]   seg;
   logic [1:0]   an;

   modport master (
      output count,
      input  count_q, zero, done, wrap, wrap_cnt, seg, an
   );

   modport slave (
      input  count,
      output count_q, zero, done, wrap, wrap_cnt, seg, an
   );
endinterface

// File: rtl/count_monitor.sv
// rtl/count_monitor.sv - countdown monitor with zero/done/wrap detection and 2-digit hex display
module count_monitor #(
   parameter int N       = 8,
   parameter int REFRESH = 50000
) (
   input logic         clk,
   input logic         rst,
   count_monitor_if.slave bus
);
   localparam int RW = (REFRESH > 2) ? $clog2(REFRESH) : 1;
   localparam logic [RW-1:0] LAST = RW'(REFRESH - 1);

   typedef enum logic {DIG0 = 1'b0, DIG1 = 1'b1} state_t;

   state_t        state;
   state_t        state_next;
   logic [RW-1:0] refcnt;
   logic [N-1:0]  count_q;
   logic [N-1:0]  prev_q;
   logic          sampled;
   logic          valid;
   logic [3:0]    wrap_cnt;
   logic          zero;
   logic          done;
   logic          wrap;
   logic [3:0]    nibble;
   logic [1:0]    an;
   logic [6:0]    seg;

   // sampled marks count_q as real data; valid marks prev_q as real data one cycle later
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= '0;
         prev_q   <= '0;
         sampled  <= 1'b0;
         valid    <= 1'b0;
         wrap_cnt <= 4'd0;
      end else begin
         count_q <= bus.count;
         prev_q  <= count_q;
         sampled <= 1'b1;
         valid   <= sampled;
         if (wrap && (wrap_cnt != 4'hF))
            wrap_cnt <= wrap_cnt + 4'd1;
      end
   end

   always_comb begin
      zero = (count_q == '0);
      done = valid && zero && (prev_q != '0);
      wrap = valid && (prev_q == '0) && (count_q == '1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         refcnt <= '0;
      else if (refcnt == LAST)
         refcnt <= '0;
      else
         refcnt <= refcnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= DIG0;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (refcnt == LAST)
         state_next = (state == DIG0) ? DIG1 : DIG0;
   end

   always_comb begin
      an     = 2'b10;
      nibble = count_q[3:0];
      if (state == DIG1) begin
         an     = 2'b01;
         nibble = count_q[7:4];
      end
   end

   // active-low {g,f,e,d,c,b,a}
   always_comb begin
      seg = 7'b1111111;
      case (nibble)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
   end

   assign bus.count_q  = count_q;
   assign bus.zero     = zero;
   assign bus.done     = done;
   assign bus.wrap     = wrap;
   assign bus.wrap_cnt = wrap_cnt;
   assign bus.seg      = seg;
   assign bus.an       = an;
endmodule

// File: tb/tb_count_monitor.sv
// tb/tb_count_monitor.sv - directed self-checking bench for count_monitor
module tb_count_monitor;
   localparam int N       = 8;
   localparam int REFRESH = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   count_monitor_if #(.N(N)) bus ();

   count_monitor #(.N(N), .REFRESH(REFRESH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.count = 8'd6;
      tick();
      tick();
      checks++; if (bus.count_q !== 8'd0) begin failures++; $display("FAIL rst_count_q actual=%0h expected=0", bus.count_q); end
      checks++; if (bus.zero !== 1'b1) begin failures++; $display("FAIL rst_zero actual=%b expected=1", bus.zero); end
      checks++; if (bus.done !== 1'b0 || bus.wrap !== 1'b0) begin failures++; $display("FAIL rst_pulses actual=%b%b expected=00", bus.done, bus.wrap); end
      checks++; if (bus.wrap_cnt !== 4'd0) begin failures++; $display("FAIL rst_wrap_cnt actual=%0d expected=0", bus.wrap_cnt); end
      checks++; if (bus.an !== 2'b10) begin failures++; $display("FAIL rst_an actual=%b expected=10", bus.an); end
      checks++; if (bus.seg !== 7'b1000000) begin failures++; $display("FAIL rst_seg actual=%b expected=1000000", bus.seg); end
      rst = 1'b0;
      tick();
      checks++; if (bus.count_q !== 8'd6) begin failures++; $display("FAIL post_rst_count_q actual=%0h expected=6", bus.count_q); end
      checks++; if (bus.zero !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL post_rst_zero_done actual=%b%b expected=00", bus.zero, bus.done); end
      checks++; if (bus.wrap_cnt !== 4'd0) begin failures++; $display("FAIL post_rst_wrap_cnt actual=%0d expected=0", bus.wrap_cnt); end
      checks++; if (bus.an !== 2'b10) begin failures++; $display("FAIL post_rst_an actual=%b expected=10", bus.an); end
      checks++; if (bus.seg !== 7'b0000010) begin failures++; $display("FAIL post_rst_seg actual=%b expected=0000010", bus.seg); end
   endtask

   task automatic test_countdown();
      logic [7:0] steps    [8] = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
      logic       done_exp [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic       zero_exp [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 8; i++) begin
         bus.count = steps[i];
         tick();
         checks++; if (bus.count_q !== steps[i]) begin failures++; $display("FAIL cd_count_q[%0d] actual=%0h expected=%0h", i, bus.count_q, steps[i]); end
         checks++; if (bus.done !== done_exp[i]) begin failures++; $display("FAIL cd_done[%0d] actual=%b expected=%b", i, bus.done, done_exp[i]); end
         checks++; if (bus.zero !== zero_exp[i]) begin failures++; $display("FAIL cd_zero[%0d] actual=%b expected=%b", i, bus.zero, zero_exp[i]); end
         checks++; if (bus.wrap !== 1'b0) begin failures++; $display("FAIL cd_wrap[%0d] actual=%b expected=0", i, bus.wrap); end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] steps    [6] = '{8'd1, 8'd0, 8'd255, 8'd255, 8'd0, 8'd254};
      logic       done_exp [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic       wrap_exp [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [3:0] wcnt_exp [6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1};
      for (int i = 0; i < 6; i++) begin
         bus.count = steps[i];
         tick();
         checks++; if (bus.done !== done_exp[i]) begin failures++; $display("FAIL wr_done[%0d] actual=%b expected=%b", i, bus.done, done_exp[i]); end
         checks++; if (bus.wrap !== wrap_exp[i]) begin failures++; $display("FAIL wr_wrap[%0d] actual=%b expected=%b", i, bus.wrap, wrap_exp[i]); end
         checks++; if (bus.wrap_cnt !== wcnt_exp[i]) begin failures++; $display("FAIL wr_wrap_cnt[%0d] actual=%0d expected=%0d", i, bus.wrap_cnt, wcnt_exp[i]); end
      end
   endtask

   task automatic test_saturate();
      int pulses = 0;
      int both   = 0;
      rst = 1'b1;
      bus.count = 8'd0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      checks++; if (bus.done !== 1'b0 || bus.zero !== 1'b1) begin failures++; $display("FAIL sat_first_zero done/zero actual=%b%b expected=01", bus.done, bus.zero); end
      tick();
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL sat_held_zero_done actual=%b expected=0", bus.done); end
      for (int k = 1; k <= 17; k++) begin
         bus.count = 8'd0;
         tick();
         if (bus.done === 1'b1 && bus.wrap === 1'b1) both++;
         checks++; if (bus.wrap_cnt !== 4'((k - 1 > 15) ? 15 : k - 1)) begin failures++; $display("FAIL sat_wrap_cnt[%0d] actual=%0d expected=%0d", k, bus.wrap_cnt, (k - 1 > 15) ? 15 : k - 1); end
         bus.count = 8'd255;
         tick();
         if (bus.wrap === 1'b1) pulses++;
         if (bus.done === 1'b1 && bus.wrap === 1'b1) both++;
      end
      bus.count = 8'd0;
      tick();
      checks++; if (bus.wrap_cnt !== 4'd15) begin failures++; $display("FAIL sat_final_wrap_cnt actual=%0d expected=15", bus.wrap_cnt); end
      checks++; if (pulses !== 17) begin failures++; $display("FAIL sat_pulses actual=%0d expected=17", pulses); end
      checks++; if (both !== 0) begin failures++; $display("FAIL sat_done_and_wrap actual=%0d expected=0", both); end
   endtask

   task automatic test_reset_mid();
      bit found = 1'b0;
      bus.count = 8'd1;
      for (int i = 0; i < 2 * REFRESH + 2 && !found; i++) begin
         tick();
         if (bus.an === 2'b01) found = 1'b1;
      end
      checks++; if (!found) begin failures++; $display("FAIL mid_reach_dig1 actual=timeout expected=an_01"); end
      rst = 1'b1;
      bus.count = 8'd0;
      tick();
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mid_rst_done actual=%b expected=0", bus.done); end
      checks++; if (bus.an !== 2'b10) begin failures++; $display("FAIL mid_rst_an actual=%b expected=10", bus.an); end
      checks++; if (bus.wrap_cnt !== 4'd0) begin failures++; $display("FAIL mid_rst_wrap_cnt actual=%0d expected=0", bus.wrap_cnt); end
      rst = 1'b0;
      tick();
      checks++; if (bus.done !== 1'b0 || bus.zero !== 1'b1) begin failures++; $display("FAIL mid_post_done_zero actual=%b%b expected=01", bus.done, bus.zero); end
      tick();
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mid_post2_done actual=%b expected=0", bus.done); end
      rst = 1'b1;
      bus.count = 8'd255;
      tick();
      rst = 1'b0;
      tick();
      checks++; if (bus.wrap !== 1'b0) begin failures++; $display("FAIL mid_first_ff_wrap actual=%b expected=0", bus.wrap); end
      tick();
      checks++; if (bus.wrap !== 1'b0 || bus.wrap_cnt !== 4'd0) begin failures++; $display("FAIL mid_held_ff wrap/cnt actual=%b/%0d expected=0/0", bus.wrap, bus.wrap_cnt); end
   endtask

   task automatic test_decode();
      logic [6:0] seg_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                   7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      for (int i = 0; i < 16; i++) begin
         bus.count = {4'(i), 4'(i)};
         tick();
         checks++; if (bus.seg !== seg_tbl[i]) begin failures++; $display("FAIL dec_seg[%0h] actual=%b expected=%b", i, bus.seg, seg_tbl[i]); end
      end
   endtask

   task automatic test_display();
      logic [1:0] an_exp [12] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01,
                                  2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
      logic [6:0] seg_exp;
      rst = 1'b1;
      bus.count = 8'hA3;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) tick();
         seg_exp = (i == 0) ? 7'b1000000 : (an_exp[i] == 2'b10) ? 7'b0110000 : 7'b0001000;
         checks++; if (bus.an !== an_exp[i]) begin failures++; $display("FAIL disp_an[%0d] actual=%b expected=%b", i, bus.an, an_exp[i]); end
         checks++; if (bus.seg !== seg_exp) begin failures++; $display("FAIL disp_seg[%0d] actual=%b expected=%b", i, bus.seg, seg_exp); end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      bus.count = '0;
      test_reset();
      test_countdown();
      test_wrap();
      test_saturate();
      test_reset_mid();
      test_decode();
      test_display();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter N, default 8, width of the monitored count bus; N SHALL be >= 8.
REQ-002 Parameter REFRESH, default 50000, clock cycles each display digit is held; REFRESH SHALL be >= 2.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 count  input  N  value produced by the upstream countdown counter, sampled every cycle.
REQ-006 count_q  output  N  registered copy of count.
REQ-007 zero  output  1  level, high while count_q == 0.
REQ-008 done  output  1  one-cycle pulse on arrival at zero.
REQ-009 wrap  output  1  one-cycle pulse on underflow from 0 to all-ones.
REQ-010 wrap_cnt  output  4  saturating count of wrap events.
REQ-011 seg  output  7  active-low segment drive {g,f,e,d,c,b,a} for the currently selected hex digit.
REQ-012 an  output  2  active-low one-hot digit enable; an[0] = low nibble, an[1] = high nibble.

Function
REQ-013 count_q SHALL equal count from the previous cycle (1-cycle latency); prev_q SHALL hold the prior count_q (2-cycle history).
REQ-014 A valid flag SHALL clear on reset and set after the first post-reset sample; done and wrap SHALL be suppressed while prev_q is not valid.
REQ-015 zero SHALL be combinational from count_q: high iff count_q == 0, including the first cycle after reset.
REQ-016 done SHALL pulse for exactly one cycle when count_q == 0 and prev_q != 0; a count held at 0 SHALL NOT re-trigger done.
REQ-017 wrap SHALL pulse for exactly one cycle when prev_q == 0 and count_q == all-ones (2^N-1); any other 0 -> nonzero transition SHALL NOT assert wrap.
REQ-018 done and wrap SHALL never be high in the same cycle.
REQ-019 wrap_cnt SHALL increment by 1 in the cycle after each wrap pulse and SHALL saturate at 15 (no rollover).
REQ-020 Display FSM SHALL have two states: DIG0 (an = 2'b10, shows count_q[3:0]) and DIG1 (an = 2'b01, shows count_q[7:4]).
REQ-021 A refresh counter SHALL count 0..REFRESH-1; on reaching REFRESH-1 it SHALL return to 0 and the FSM SHALL toggle DIG0 <-> DIG1; each state therefore lasts exactly REFRESH cycles.
REQ-022 seg SHALL decode the selected nibble as standard hex 0-F, active-low (0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000, F -> 7'b0001110); seg SHALL track count_q within the same cycle.
REQ-023 Bits count_q[N-1:8] SHALL NOT affect seg or an when N > 8.
REQ-024 Count changes SHALL NOT reset or stall the refresh counter or the display FSM.

Reset
REQ-025 While rst is high at a clock edge: count_q = 0, prev_q = 0, valid = 0, done = 0, wrap = 0, wrap_cnt = 0, refresh counter = 0, FSM = DIG0 (an = 2'b10, seg = 7'b1000000).
REQ-026 Reset asserted mid-operation SHALL take effect on the next edge regardless of FSM state or pending pulses; a zero present on the first sample after reset SHALL NOT produce done.

Verification
REQ-027 rst high for 2 cycles, count = 8'd6 -> after reset: count_q = 6 one cycle later, zero = 0, done = 0, wrap_cnt = 0, an = 2'b10, seg = 7'b0000010.
REQ-028 count steps 6,5,4,3,2,1,0,0,0 -> done high for exactly the single cycle in which count_q first becomes 0; zero stays high on the following cycles; wrap stays 0.
REQ-029 count steps 1,0,255 -> done pulses when count_q = 0, wrap pulses when count_q = 255 on the next cycle, wrap_cnt = 1 one cycle after that.
REQ-030 Drive 17 separate 0 -> 255 transitions -> wrap_cnt reads 15 after the 15th and remains 15; 17 wrap pulses are observed.
REQ-031 REFRESH = 4, count = 8'hA3 held -> an alternates 10,10,10,10,01,01,01,01,...; seg = 7'b0110000 (3) under an = 10 and 7'b0001000 (A) under an = 01.
REQ-032 Reset count = 0 held through and after rst release; separately assert rst during DIG1 with a done pulse pending -> no done after either reset, an = 2'b10, wrap_cnt = 0 on the next edge.
